// File: rtl/lor_pkg.sv
// Shared definitions for the pipelined 12-bit subtractor (lor_sub_pipe).
// Holds the word width, the stage split point and the default number of
// approximate low bits, plus the stage-1 register layout.
// No ports (package).
package lor_pkg;

  localparam int LOR_WIDTH    = 12;
  localparam int LOR_SPLIT    = 6;
  localparam int LOR_BITS_DEF = 4;

  typedef logic [LOR_WIDTH-1:0] lor_word_t;

  // Stage-1 register: the finished low half of the difference, the borrow
  // leaving it, and the untouched upper operand bits for stage 2.
  typedef struct packed {
    logic [LOR_SPLIT-1:0]           diff_lo;
    logic                           borrow;
    logic [LOR_WIDTH-LOR_SPLIT-1:0] a_hi;
    logic [LOR_WIDTH-LOR_SPLIT-1:0] b_hi;
  } s1_t;

endpackage

// File: rtl/lor_sub_pipe_if.sv
// Operand/result bundle for lor_sub_pipe.
// Signals:
//   in_valid, in_ready, A, B, Bin   : operand channel (upstream -> block)
//   out_valid, out_ready, Diff, Bout: result channel  (block -> downstream)
// Modports:
//   master : the side that supplies operands and consumes results
//   slave  : the subtractor itself
//
// Handshake: a transfer happens on a rising clk edge where valid & ready are
// both 1. Once valid is raised, the sender holds it and the payload steady
// until that transfer; ready may be driven by either state of valid, and
// valid never waits on ready.
interface lor_sub_pipe_if;
  import lor_pkg::*;

  logic      in_valid;
  logic      in_ready;
  lor_word_t A;
  lor_word_t B;
  logic      Bin;
  logic      out_valid;
  logic      out_ready;
  lor_word_t Diff;
  logic      Bout;

  modport master (
    output in_valid, A, B, Bin, out_ready,
    input  in_ready, out_valid, Diff, Bout
  );

  modport slave (
    input  in_valid, A, B, Bin, out_ready,
    output in_ready, out_valid, Diff, Bout
  );

endinterface

// File: rtl/sub_slice.sv
// sub_slice: combinational N-bit ripple-borrow subtractor, d = a - b - bin.
// Ports:
//   d    out N  difference bits
//   bout out 1  borrow out of the top bit
//   a    in  N  minuend bits
//   b    in  N  subtrahend bits
//   bin  in  1  borrow into bit 0
module sub_slice #(
  parameter int N = 6
) (
  output logic [N-1:0] d,
  output logic         bout,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         bin
);

  // bw[i] is the borrow into bit i; each bit owns exactly one link.
  logic [N:0] bw;

  assign bw[0] = bin;

  for (genvar i = 0; i < N; i++) begin : g_bit
    assign d[i]    = a[i] ^ b[i] ^ bw[i];
    // Borrow when a<b at this bit, or equal bits with a borrow arriving.
    assign bw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & bw[i]);
  end

  assign bout = bw[N];

endmodule

// File: rtl/lor_sub_pipe.sv
// lor_sub_pipe: two-stage pipelined 12-bit subtractor, Diff = A - B - Bin
// modulo 2^12, Bout = 1 when A < B + Bin (unsigned).
// Stage 1 resolves the low SPLIT bits and registers the borrow leaving them;
// stage 2 ripples the upper bits from that borrow. Latency 2, one result per
// cycle, full valid/ready backpressure on both sides.
// Ports:
//   clk  in  rising-edge clock
//   rst  in  asynchronous active-high reset (clears both stages)
//   bus  lor_sub_pipe_if.slave: in_valid/in_ready/A/B/Bin in,
//        out_valid/out_ready/Diff/Bout out
// Build option: define LOR_APPROX_EN to replace the low LOR_BITS bits with
// A ^ B (Bin ignored) and a borrow of ~A[LOR_BITS-1] & B[LOR_BITS-1] into
// the next bit; everything above stays exact.
module lor_sub_pipe
  import lor_pkg::*;
(
  input logic           clk,
  input logic           rst,
  lor_sub_pipe_if.slave bus
);

  localparam int WIDTH = LOR_WIDTH;
  localparam int SPLIT = LOR_SPLIT;

  // ---------------------------------------------------------------- stage 1
  logic [SPLIT-1:0] lo_d;
  logic             lo_bw;

`ifdef LOR_APPROX_EN
  localparam int LOR_BITS = LOR_BITS_DEF;

  logic [LOR_BITS-1:0] apx_d;
  logic                apx_bw;

  assign apx_d  = bus.A[LOR_BITS-1:0] ^ bus.B[LOR_BITS-1:0];
  assign apx_bw = ~bus.A[LOR_BITS-1] & bus.B[LOR_BITS-1];

  if (LOR_BITS < SPLIT) begin : g_mid
    // Exact ripple over the low-half bits that sit above the approximate part.
    logic [SPLIT-LOR_BITS-1:0] mid_d;

    sub_slice #(.N(SPLIT-LOR_BITS)) u_lo (
      .d    (mid_d),
      .bout (lo_bw),
      .a    (bus.A[SPLIT-1:LOR_BITS]),
      .b    (bus.B[SPLIT-1:LOR_BITS]),
      .bin  (apx_bw)
    );

    assign lo_d = {mid_d, apx_d};
  end else begin : g_no_mid
    assign lo_d  = apx_d;
    assign lo_bw = apx_bw;
  end
`else
  sub_slice #(.N(SPLIT)) u_lo (
    .d    (lo_d),
    .bout (lo_bw),
    .a    (bus.A[SPLIT-1:0]),
    .b    (bus.B[SPLIT-1:0]),
    .bin  (bus.Bin)
  );
`endif

  s1_t  s1_next;
  s1_t  s1;
  logic s1_valid;

  assign s1_next.diff_lo = lo_d;
  assign s1_next.borrow  = lo_bw;
  assign s1_next.a_hi    = bus.A[WIDTH-1:SPLIT];
  assign s1_next.b_hi    = bus.B[WIDTH-1:SPLIT];

  // ---------------------------------------------------------------- stage 2
  logic [WIDTH-SPLIT-1:0] hi_d;
  logic                   hi_bw;

  sub_slice #(.N(WIDTH-SPLIT)) u_hi (
    .d    (hi_d),
    .bout (hi_bw),
    .a    (s1.a_hi),
    .b    (s1.b_hi),
    .bin  (s1.borrow)
  );

  logic      s2_valid;
  lor_word_t diff_q;
  logic      bout_q;

  // A stage may load whenever the stage after it is empty or draining this
  // cycle. in_ready therefore depends only on registered state and
  // out_ready, never on in_valid.
  logic s2_load;
  logic in_ready;

  assign s2_load  = ~s2_valid | bus.out_ready;
  assign in_ready = ~s1_valid | s2_load;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1       <= '0;
      s2_valid <= 1'b0;
      diff_q   <= '0;
      bout_q   <= 1'b0;
    end else begin
      if (in_ready) begin
        s1_valid <= bus.in_valid;
        if (bus.in_valid) begin
          s1 <= s1_next;
        end
      end
      // Holding s2 while out_ready is low keeps Diff/Bout stable.
      if (s2_load) begin
        s2_valid <= s1_valid;
        if (s1_valid) begin
          diff_q <= {hi_d, s1.diff_lo};
          bout_q <= hi_bw;
        end
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid;
  assign bus.Diff      = diff_q;
  assign bus.Bout      = bout_q;

endmodule
